// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: per-frame vertical bird physics, bounding box and IDLE/PLAY/DEAD game state
module bird_motion_ctrl #(
  parameter int BIRD_X   = 100,
  parameter int BIRD_W   = 16,
  parameter int BIRD_H   = 12,
  parameter int START_Y  = 200,
  parameter int SCREEN_H = 480,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 8,
  parameter int MAX_FALL = 10
) (
  input  logic        clkf,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap,
  input  logic        collide,
  input  logic        restart,
  output logic [10:0] llx,
  output logic [10:0] lly,
  output logic [10:0] trx,
  output logic [10:0] try,
  output logic        playing,
  output logic        dead
);
  typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;
  localparam logic signed [5:0]  GRV   = 6'(GRAVITY);
  localparam logic signed [5:0]  MAXF  = 6'(MAX_FALL);
  localparam logic signed [5:0]  FLAPV = -6'(FLAP_VEL);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BIRD_H);
  localparam logic [10:0]        Y0    = 11'(START_Y);
  state_t             state_q, state_d;
  logic signed [5:0]  vel_q, vel_d, vel_inc, vel_new;
  logic               pend_q, pend_d;
  logic [10:0]        lly_q, lly_d, try_q, try_d;
  logic signed [11:0] ny;
  assign llx     = 11'(BIRD_X);
  assign trx     = 11'(BIRD_X + BIRD_W - 1);
  assign lly     = lly_q;
  assign try     = try_q;
  assign playing = state_q == PLAY;
  assign dead    = state_q == DEAD;
  // a flap arriving in the same cycle as the tick is consumed by that tick
  always_comb begin
    vel_inc = vel_q + GRV;
    vel_new = (pend_q | flap) ? FLAPV : (vel_inc > MAXF ? MAXF : vel_inc);
    ny      = $signed({1'b0, lly_q}) + $signed({{6{vel_new[5]}}, vel_new});
    state_d = state_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    lly_d   = lly_q;
    if (state_q == IDLE) begin
      state_d = flap ? PLAY : IDLE;
      pend_d  = flap;
    end else if (state_q == PLAY) begin
      if (collide) begin
        state_d = DEAD;
        vel_d   = '0;
        pend_d  = 1'b0;
      end else if (frame_tick) begin
        pend_d  = 1'b0;
        state_d = ny > Y_MAX ? DEAD : PLAY;
        lly_d   = ny < 0 ? 11'd0 : (ny > Y_MAX ? Y_MAX[10:0] : ny[10:0]);
        vel_d   = (ny < 0 || ny > Y_MAX) ? 6'sd0 : vel_new;
      end else begin
        pend_d  = pend_q | flap;
      end
    end else if (restart) begin
      state_d = IDLE;
      vel_d   = '0;
      pend_d  = 1'b0;
      lly_d   = Y0;
    end
    try_d = lly_d + 11'(BIRD_H - 1);
  end
  // game state, physics and box registers; box only moves on a consumed tick or restart
  always_ff @(posedge clkf or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vel_q   <= '0;
      pend_q  <= 1'b0;
      lly_q   <= Y0;
      try_q   <= Y0 + 11'(BIRD_H - 1);
    end else begin
      state_q <= state_d;
      vel_q   <= vel_d;
      pend_q  <= pend_d;
      lly_q   <= lly_d;
      try_q   <= try_d;
    end
  end
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb_bird_motion_ctrl: scoreboard bench driving directed frame/flap/collide/restart vectors
module tb_bird_motion_ctrl;
  logic        clkf = 1'b0, reset = 1'b1;
  logic        frame_tick = 1'b0, flap = 1'b0, collide = 1'b0, restart = 1'b0;
  logic [10:0] llx, lly, trx, try;
  logic        playing, dead;
  int          compared = 0, mismatched = 0;
  int          eq_y[$];
  bit          eq_p[$], eq_d[$];
  string       eq_n[$];
  event        sample_now;
  int          path[23] = '{192, 185, 179, 174, 170, 167, 165, 164, 164, 165, 167, 170,
                            174, 179, 185, 192, 200, 209, 219, 229, 239, 249, 259};

  bird_motion_ctrl dut (
    .clkf(clkf), .reset(reset), .frame_tick(frame_tick), .flap(flap), .collide(collide),
    .restart(restart), .llx(llx), .lly(lly), .trx(trx), .try(try), .playing(playing), .dead(dead)
  );

  always #5 clkf = ~clkf;

  task automatic expect_box(input int y, input bit p, input bit d, input string nm);
    eq_y.push_back(y);
    eq_p.push_back(p);
    eq_d.push_back(d);
    eq_n.push_back(nm);
  endtask

  task automatic step(input bit t, input bit f, input bit c, input bit r,
                      input int y, input bit p, input bit d, input string nm);
    @(negedge clkf);
    frame_tick = t; flap = f; collide = c; restart = r;
    @(posedge clkf);
    #1;
    frame_tick = 0; flap = 0; collide = 0; restart = 0;
    expect_box(y, p, d, nm);
  endtask

  // monitor: registered box is stable between edges, so sample at the falling edge
  always @(negedge clkf or sample_now) begin
    if (eq_y.size() > 0) begin
      int  y;
      bit  p, d;
      string nm;
      y = eq_y.pop_front(); p = eq_p.pop_front(); d = eq_d.pop_front(); nm = eq_n.pop_front();
      compared++;
      if (lly !== 11'(y) || try !== 11'(y + 11) || llx !== 11'd100 || trx !== 11'd115 ||
          playing !== p || dead !== d) begin
        mismatched++;
        $display("FAIL %s: got llx=%0d lly=%0d trx=%0d try=%0d playing=%0b dead=%0b, want llx=100 lly=%0d trx=115 try=%0d playing=%0b dead=%0b",
                 nm, llx, lly, trx, try, playing, dead, y, y + 11, p, d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clkf);
    #1 reset = 0;
    expect_box(200, 0, 0, "reset");
    step(1, 0, 0, 0, 200, 0, 0, "idle_tick0");
    step(1, 0, 0, 0, 200, 0, 0, "idle_tick1");
    step(0, 0, 0, 1, 200, 0, 0, "idle_restart");
    step(0, 1, 0, 0, 200, 1, 0, "start");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, path[i], 1, 0, "first_ticks");
    step(0, 0, 0, 0, 179, 1, 0, "hold_no_tick");
    for (int i = 3; i < 23; i++) step(1, 0, 0, 0, path[i], 1, 0, "fall_saturate");
    step(0, 1, 0, 0, 259, 1, 0, "flap_pending");
    step(1, 0, 0, 0, 251, 1, 0, "pending_flap_tick");
    for (int k = 1; k <= 31; k++) step(1, 1, 0, 0, 251 - 8 * k, 1, 0, "climb");
    step(1, 1, 0, 0, 0, 1, 0, "ceiling_clamp");
    step(1, 0, 0, 0, 1, 1, 0, "after_ceiling");
    step(1, 1, 0, 0, 0, 1, 0, "flap_with_tick");
    for (int i = 1; i <= 51; i++)
      step(1, 0, 0, 0, i <= 10 ? i * (i + 1) / 2 : 55 + 10 * (i - 10), 1, 0, "floor_fall");
    step(1, 0, 0, 0, 468, 0, 1, "floor_hit");
    step(0, 1, 0, 0, 468, 0, 1, "dead_flap");
    step(1, 0, 0, 0, 468, 0, 1, "dead_tick");
    step(0, 0, 0, 1, 200, 0, 0, "dead_restart");
    step(0, 1, 0, 0, 200, 1, 0, "restart_play");
    for (int i = 0; i < 22; i++) step(1, 0, 0, 0, path[i], 1, 0, "refall");
    step(1, 0, 1, 0, 249, 0, 1, "collide_tick");
    step(1, 0, 0, 0, 249, 0, 1, "collide_frozen");
    step(0, 0, 0, 1, 200, 0, 0, "collide_restart");
    step(0, 1, 0, 0, 200, 1, 0, "replay");
    step(1, 0, 0, 0, 192, 1, 0, "replay_tick");
    step(0, 1, 0, 0, 192, 1, 0, "pend_before_reset");
    @(negedge clkf);
    #2 reset = 1;
    #1;
    expect_box(200, 0, 0, "async_reset");
    -> sample_now;
    #1 reset = 0;
    step(1, 0, 0, 0, 200, 0, 0, "post_reset_tick");
    repeat (3) @(negedge clkf);
    if (eq_y.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", eq_y.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
